// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter slice: byte width, arbiter
// states and a constant-friendly clog2.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    WAIT_IDLE = 2'd3
  } arb_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin selector: first set request bit strictly after ptr,
// scanning upward with wrap.
module uart_rr_picker
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               any,
  output logic [ID_W-1:0]    idx
);

  logic [ID_W-1:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((32'(ptr) + i) % NUM_REQ);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between NUM_REQ
// requesters; sequences start/busy/done and returns per-requester completion.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = UART_DATA_W,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           req_done,
  output logic [DATA_W-1:0]            tx_data,
  output logic                         tx_start,
  input  logic                         tx_busy,
  input  logic                         tx_done,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         active,
  output logic                         timeout_err
);

  localparam int unsigned ID_W  = clog2(NUM_REQ);
  localparam int unsigned CNT_W = (clog2(ACK_TIMEOUT) > 0) ? clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  arb_state_t       state;
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] cnt;
  logic             pick_any;
  logic [ID_W-1:0]  pick_idx;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req (req_valid),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // active tracks the state being entered, so it is updated on every transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= ID_W'(NUM_REQ - 1);
      cnt         <= '0;
      req_ready   <= '0;
      req_done    <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      grant_id    <= '0;
      active      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      req_ready <= '0;
      req_done  <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            tx_data   <= req_data[32'(pick_idx) * DATA_W +: DATA_W];
            grant_id  <= pick_idx;
            ptr       <= pick_idx;
            req_ready <= NUM_REQ'(1) << pick_idx;
            tx_start  <= 1'b1;
            cnt       <= '0;
            state     <= WAIT_BUSY;
            active    <= 1'b1;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            tx_start <= 1'b0;
            state    <= WAIT_DONE;
          end else if (cnt == CNT_LAST) begin
            tx_start    <= 1'b0;
            timeout_err <= 1'b1;
            state       <= IDLE;
            active      <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // busy falls before the parity bit, so only done marks frame completion
        WAIT_DONE: begin
          if (tx_done) begin
            req_done <= NUM_REQ'(1) << grant_id;
            state    <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (!tx_done) begin
            state  <= IDLE;
            active <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural UART transmitter
// (2 clocks per bit, busy drops before parity, done held 2 cycles).
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int CPB     = 2;
  localparam int ACK_TO  = 16;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_REQ-1:0]      req_valid = '0;
  logic [NUM_REQ*DW-1:0]   req_data = '0;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0]      req_done;
  logic [DW-1:0]           tx_data;
  logic                    tx_start;
  logic                    tx_busy = 1'b0;
  logic                    tx_done = 1'b0;
  logic [1:0]              grant_id;
  logic                    active;
  logic                    timeout_err;

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .DATA_W      (DW),
    .ACK_TIMEOUT (ACK_TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .req_done    (req_done),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .active      (active),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] src_q [NUM_REQ][$];
  logic [7:0] exp_bytes [$];
  int         exp_done [$];
  int         grant_log [$];
  int         done_cnt [NUM_REQ];
  int         mptr = NUM_REQ - 1;
  logic       xmtr_en = 1'b1;
  logic       chk_rise = 1'b1;
  logic       m_serial = 1'b1;
  logic       m_idle = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first valid requester strictly after the last grant, with wrap.
  function automatic int next_grant(input logic [NUM_REQ-1:0] v, input int p);
    for (int j = 1; j <= NUM_REQ; j++) begin
      if (v[(p + j) % NUM_REQ]) return (p + j) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic int pending_total();
    int s = 0;
    for (int i = 0; i < NUM_REQ; i++) s += src_q[i].size();
    return s;
  endfunction

  // Behavioural transmitter: start, 8 data bits LSB first, even parity, stop.
  initial begin
    logic [10:0] frame;
    forever begin
      @(posedge clk);
      if (xmtr_en && tx_start) begin
        frame  = {1'b1, ^tx_data, tx_data, 1'b0};
        m_idle = 1'b0;
        #1;
        for (int b = 0; b < 11; b++) begin
          m_serial = frame[b];
          tx_busy  = (b < 9);
          repeat (CPB) @(posedge clk);
          #1;
        end
        tx_done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tx_done = 1'b0;
        m_idle  = 1'b1;
      end
    end
  end

  // Serial-line monitor: decodes each frame and pops the expected byte.
  initial begin
    logic [7:0] b;
    logic       par;
    logic       stp;
    forever begin
      @(negedge m_serial);
      #30;
      for (int i = 0; i < 8; i++) begin
        b[i] = m_serial;
        #20;
      end
      par = m_serial;
      #20;
      stp = m_serial;
      chk("frame_parity", par, ^b);
      chk("frame_stop", stp, 1);
      if (exp_bytes.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL frame_unexpected actual=%0h required=none", b);
      end else begin
        chk("frame_byte", b, exp_bytes.pop_front());
      end
    end
  end

  // Completion monitor.
  initial begin
    int k;
    forever begin
      @(negedge clk);
      if (rst_n && req_done != '0) begin
        if (exp_done.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected actual=%b required=none", req_done);
        end else begin
          k = exp_done.pop_front();
          chk("req_done_onehot", req_done, 64'(1) << k);
        end
        for (int i = 0; i < NUM_REQ; i++) if (req_done[i]) done_cnt[i]++;
      end
    end
  end

  // Requester driver plus grant reference model.
  initial begin
    int   k;
    logic prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mptr = NUM_REQ - 1;
      end else begin
        if (tx_start && !prev_start && chk_rise)
          chk("start_rise_line_idle", {tx_busy, tx_done}, 0);
        if (req_ready != '0) begin
          k = next_grant(req_valid, mptr);
          chk("grant_id", grant_id, k);
          chk("req_ready_onehot", req_ready, (k >= 0) ? (64'(1) << k) : 64'(0));
          chk("tx_start_at_grant", tx_start, 1);
          if (k >= 0) begin
            chk("tx_data", tx_data, src_q[k][0]);
            if (xmtr_en) begin
              exp_bytes.push_back(src_q[k][0]);
              exp_done.push_back(k);
            end
            mptr = k;
          end
          grant_log.push_back(int'(grant_id));
          for (int i = 0; i < NUM_REQ; i++)
            if (req_ready[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        end
      end
      prev_start = tx_start;
      for (int i = 0; i < NUM_REQ; i++) begin
        req_valid[i]         = (src_q[i].size() != 0);
        req_data[i*DW +: DW] = (src_q[i].size() != 0) ? src_q[i][0] : 8'h00;
      end
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while ((pending_total() != 0 || exp_bytes.size() != 0 || exp_done.size() != 0 ||
            active || !m_idle) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk(name, n < 4000, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_req_done"}, req_done, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_active"}, active, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    int order02 [6] = '{0, 2, 0, 2, 0, 2};
    int n;
    int hi;
    int d0;

    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All four at once from reset pointer: expect 0,1,2,3.
    grant_log.delete();
    src_q[0].push_back(8'h11);
    src_q[1].push_back(8'h22);
    src_q[2].push_back(8'h33);
    src_q[3].push_back(8'h44);
    wait_idle("all4_complete");
    chk("all4_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("all4_order", grant_log[i], i);

    // Requesters 0 and 2 continuously valid.
    grant_log.delete();
    for (int i = 0; i < 3; i++) begin
      src_q[0].push_back(8'(8'hA0 + i));
      src_q[2].push_back(8'(8'hC0 + i));
    end
    wait_idle("rr02_complete");
    chk("rr02_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) chk("rr02_order", grant_log[i], order02[i]);

    // Single request.
    grant_log.delete();
    d0 = done_cnt[0];
    src_q[0].push_back(8'hA5);
    wait_idle("single_complete");
    chk("single_grants", grant_log.size(), 1);
    chk("single_done_pulses", done_cnt[0] - d0, 1);

    // Back-to-back from requester 1.
    grant_log.delete();
    d0 = done_cnt[1];
    src_q[1].push_back(8'h5A);
    src_q[1].push_back(8'hC3);
    wait_idle("b2b_complete");
    chk("b2b_grants", grant_log.size(), 2);
    chk("b2b_done_pulses", done_cnt[1] - d0, 2);

    // Transmitter never acknowledges: abort after ACK_TIMEOUT cycles of start.
    grant_log.delete();
    xmtr_en = 1'b0;
    src_q[3].push_back(8'h77);
    n = 0;
    while (!tx_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_start_seen", tx_start, 1);
    hi = 0;
    while (tx_start && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    chk("timeout_start_cycles", hi, ACK_TO);
    chk("timeout_err_set", timeout_err, 1);
    chk("timeout_active_low", active, 0);
    repeat (5) @(negedge clk);
    chk("timeout_err_sticky", timeout_err, 1);
    xmtr_en = 1'b1;
    src_q[3].push_back(8'h88);
    wait_idle("regrant_complete");
    chk("regrant_grants", grant_log.size(), 2);
    chk("timeout_err_still", timeout_err, 1);

    // Randomised traffic.
    for (int r = 0; r < 40; r++) begin
      src_q[$urandom_range(0, NUM_REQ - 1)].push_back(8'($urandom));
      repeat ($urandom_range(0, 25)) @(negedge clk);
    end
    wait_idle("random_complete");

    // Reset while the arbiter waits for done; the transmitter keeps running.
    src_q[2].push_back(8'h3C);
    n = 0;
    while (!tx_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    while (tx_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("midframe_reached", n < 200, 1);
    chk_rise = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("async_reset");
    exp_done.delete();
    @(negedge clk);
    rst_n = 1'b1;
    grant_log.delete();
    src_q[1].push_back(8'h96);
    wait_idle("post_reset_complete");
    chk("post_reset_grants", grant_log.size(), 1);
    if (grant_log.size() != 0) chk("post_reset_grant_id", grant_log[0], 1);
    chk("post_reset_no_timeout", timeout_err, 0);
    chk_rise = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART_Tx byte transmitter between NUM_REQ requesters.
- Each requester offers a byte through a valid/ready handshake. The block grants requesters in round-robin order and drives the transmitter's data_in/start_sending pair.
- It sequences the transmitter's busy/done pair and returns a per-requester completion pulse.
- It sits between the byte producers (command/status sources) and UART_Tx.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; must match the transmitter's data_in width.
- ACK_TIMEOUT, 16, max cycles tx_start is held waiting for tx_busy before abort.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester byte offered; held with data until req_ready.
- req_data  in  NUM_REQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
- req_done  out  NUM_REQ  one-hot, one-cycle pulse when the granted byte's frame finished.
- tx_data  out  DATA_W  to transmitter data_in; stable from grant until the next grant.
- tx_start  out  1  to transmitter start_sending.
- tx_busy  in  1  from transmitter busy.
- tx_done  in  1  from transmitter done.
- grant_id  out  $clog2(NUM_REQ)  index of current/last granted requester.
- active  out  1  high whenever the FSM is not in IDLE.
- timeout_err  out  1  sticky; set on an ACK_TIMEOUT abort.

Behaviour:
- Reset: one clock clk; reset rst_n is asynchronous and active-low.
  - All outputs go to 0 immediately: req_ready, req_done, tx_data, tx_start, grant_id, active, timeout_err.
  - FSM goes to IDLE, rr pointer to NUM_REQ-1, timeout counter to 0.
  - The transmitter is not reset by this block. After reset mid-frame, the next grant relies on the WAIT_BUSY hold and timeout.
- All outputs are registered.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE, WAIT_IDLE.
- IDLE:
  - If no req_valid bit is set, stay.
  - Otherwise select g = first set bit scanning from (ptr+1) mod NUM_REQ upward, with wrap.
  - On that edge: tx_data<=req_data[g], grant_id<=g, ptr<=g, req_ready[g]<=1, tx_start<=1, counter<=0, go to WAIT_BUSY.
  - Result: ready and start are both visible in the cycle after selection. Latency from valid to ready is 1 cycle.
- WAIT_BUSY:
  - req_ready clears after 1 cycle.
  - tx_start stays high until tx_busy==1 is sampled; then tx_start<=0 and go to WAIT_DONE.
  - The counter increments each cycle. If it reaches ACK_TIMEOUT-1 without tx_busy: tx_start<=0, timeout_err<=1, go to IDLE, no req_done.
  - tx_start is high for exactly ACK_TIMEOUT cycles in that case.
- WAIT_DONE:
  - Completion is judged on tx_done only, never on tx_busy, because busy drops before the parity bit.
  - On tx_done==1: req_done[grant_id]<=1 for one cycle, go to WAIT_IDLE.
- WAIT_IDLE:
  - The transmitter holds done high for 2 cycles.
  - On tx_done==0: go to IDLE. The transmitter is then guaranteed in its idle state.
  - Next grant is at the earliest the following edge.
- Invariant: tx_start is never 1 while the FSM is in WAIT_DONE or WAIT_IDLE. Exactly one req_done pulse per successful grant.
- req_valid changes outside IDLE are ignored. A requester dropping valid before ready is simply not granted.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 frames.
- active = registered (next_state != IDLE).

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_W=8
  - arbiter state encoding (2-bit localparams IDLE=0, WAIT_BUSY=1, WAIT_DONE=2, WAIT_IDLE=3)
  - the clog2 helper
- One natural sub-module: uart_rr_picker.
  - Combinational round-robin selector.
  - Inputs: req vector, ptr.
  - Outputs: any, index g.
  - Instantiated once.

Test Plan:
- Single request: uses a transmitter model with CLKs_per_bit=2.
  - Stimulus: req_valid=4'b0001, req_data[0]=8'hA5.
  - Required response: one cycle later req_ready=4'b0001 and tx_start=1, tx_data=8'hA5, grant_id=0.
  - Serial line carries A5 LSB-first; exactly one req_done[0] pulse.
- All four valid at once, data 8'h11, 8'h22, 8'h33, 8'h44:
  - Grants occur in order 0,1,2,3 and frames appear in that order.
  - tx_start never rises while tx_busy or tx_done is 1.
- Requesters 0 and 2 valid continuously for 6 bytes: grant_id sequence is 0,2,0,2,0,2 and requester 1/3 are never granted.
- Timeout: tx_busy tied 0, ACK_TIMEOUT=16, one request.
  - tx_start is high exactly 16 cycles, then timeout_err=1 and remains set.
  - No req_done; active returns to 0; a subsequent request is re-granted.
- Reset mid-frame: rst_n=0 during WAIT_DONE.
  - All outputs are 0 in the same cycle, before the next clock edge.
  - After release with req_valid=4'b0010, requester 1 is granted once the transmitter returns to idle. The grant needs no timeout if the model finishes in under ACK_TIMEOUT.
- Back-to-back, requester 1 sending 8'h5A then 8'hC3:
  - The second tx_start rises only after tx_done falls.
  - Exactly two req_done[1] pulses are produced.
